// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state encoding and header marker for the UART TX arbiter
// (header feature enabled by macro UART_ARB_HDR_EN).
package uart_pkg;

    // ST_HDR is only reachable when UART_ARB_HDR_EN is defined
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_XFER = 2'd2
    } state_t;

    // MSB of a header byte, marking it apart from the channel index below it
    localparam logic HDR_MARK = 1'b1;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin first-set search from a pointer, wrapping
// modulo P_N. Returns a one-hot grant, the grant index and an any-request flag.
module rr_pick #(
    parameter  int P_N = 4,
    localparam int W   = $clog2(P_N)
) (
    input  logic [P_N-1:0] i_req,
    input  logic [W-1:0]   i_ptr,
    output logic [P_N-1:0] o_grant,
    output logic [W-1:0]   o_idx,
    output logic           o_any
);

    logic [W:0]   w_sum;
    logic [W-1:0] w_pos;

    // walk P_N positions starting at the pointer and keep the first requester
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_sum   = '0;
        w_pos   = '0;
        for (int i = 0; i < P_N; i++) begin
            w_sum = {1'b0, i_ptr} + (W+1)'(i);
            w_pos = (w_sum >= (W+1)'(P_N)) ? W'(w_sum - (W+1)'(P_N)) : w_sum[W-1:0];
            if (!o_any && i_req[w_pos]) begin
                o_any          = 1'b1;
                o_idx          = w_pos;
                o_grant[w_pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-level round-robin sharing of one UART TX between
// P_NUM_CH byte-stream producers. Define UART_ARB_HDR_EN to prefix each grant
// with a header byte {1'b1, channel index}.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int P_NUM_CH          = 4,
    parameter int P_UART_DATA_WIDTH = 8,
    parameter int P_MAX_BURST       = 16
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic [P_NUM_CH*P_UART_DATA_WIDTH-1:0] i_req_data,
    input  logic [P_NUM_CH-1:0]                   i_req_valid,
    input  logic [P_NUM_CH-1:0]                   i_req_last,
    output logic [P_NUM_CH-1:0]                   o_req_ready,
    output logic [P_UART_DATA_WIDTH-1:0]          o_tx_data,
    output logic                                  o_tx_valid,
    input  logic                                  i_tx_ready,
    output logic [P_NUM_CH-1:0]                   o_grant,
    output logic                                  o_busy
);

    localparam int LP_DW = P_UART_DATA_WIDTH;
    localparam int LP_IW = $clog2(P_NUM_CH);
    localparam int LP_CW = $clog2(P_MAX_BURST + 1);

    state_t              r_state;
    logic [P_NUM_CH-1:0] r_grant;
    logic [LP_IW-1:0]    r_idx;
    logic [LP_IW-1:0]    r_ptr;
    logic [LP_CW-1:0]    r_cnt;
    logic                r_busy;

    logic [P_NUM_CH-1:0] w_pick;
    logic [LP_IW-1:0]    w_pick_idx;
    logic                w_any;
    logic                w_hdr;
    logic                w_xfer;
    logic                w_valid;
    logic                w_accept;
    logic                w_release;
    logic [LP_DW-1:0]    w_hdr_byte;
    logic [LP_DW-1:0]    w_data;

    rr_pick #(.P_N(P_NUM_CH)) u_rr_pick (
        .i_req   (i_req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_pick),
        .o_idx   (w_pick_idx),
        .o_any   (w_any)
    );

    assign w_hdr      = (r_state == ST_HDR);
    assign w_xfer     = (r_state == ST_XFER);
    assign w_hdr_byte = {HDR_MARK, (LP_DW-1)'(r_idx)};
    assign w_valid    = w_hdr | (w_xfer & i_req_valid[r_idx]);
    assign w_data     = w_hdr ? w_hdr_byte : i_req_data[r_idx*LP_DW +: LP_DW];
    assign w_accept   = w_xfer & i_req_valid[r_idx] & i_tx_ready;
    // last byte or the burst limit both end the grant on the accepting cycle
    assign w_release  = w_accept & (i_req_last[r_idx] | (r_cnt == LP_CW'(P_MAX_BURST - 1)));

    assign o_tx_valid  = w_valid;
    assign o_tx_data   = w_data & {LP_DW{w_valid}};
    assign o_req_ready = (w_xfer & i_tx_ready) ? r_grant : '0;
    assign o_grant     = r_grant;
    assign o_busy      = r_busy;

    // grant FSM: pick in IDLE, optionally emit header, stream until last or burst limit
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_idx   <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_pick;
                        r_idx   <= w_pick_idx;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
`ifdef UART_ARB_HDR_EN
                        r_state <= ST_HDR;
`else
                        r_state <= ST_XFER;
`endif
                    end
                end
`ifdef UART_ARB_HDR_EN
                ST_HDR: begin
                    if (i_tx_ready) r_state <= ST_XFER;
                end
`endif
                ST_XFER: begin
                    if (w_release) begin
                        r_state <= ST_IDLE;
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_ptr   <= (r_idx == LP_IW'(P_NUM_CH - 1)) ? '0 : r_idx + LP_IW'(1);
                    end else if (w_accept) begin
                        r_cnt <= r_cnt + LP_CW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized checks of uart_tx_arbiter against a packet-queue reference model.
module tb_uart_tx_arbiter;

    localparam int NCH  = 4;
    localparam int DW   = 8;
    localparam int MAXB = 4;
`ifdef UART_ARB_HDR_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic [NCH*DW-1:0] i_req_data;
    logic [NCH-1:0]    i_req_valid;
    logic [NCH-1:0]    i_req_last;
    logic [NCH-1:0]    o_req_ready;
    logic [DW-1:0]     o_tx_data;
    logic              o_tx_valid;
    logic              i_tx_ready;
    logic [NCH-1:0]    o_grant;
    logic              o_busy;

    always #5 i_clk = ~i_clk;

    uart_tx_arbiter #(
        .P_NUM_CH          (NCH),
        .P_UART_DATA_WIDTH (DW),
        .P_MAX_BURST       (MAXB)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req_data  (i_req_data),
        .i_req_valid (i_req_valid),
        .i_req_last  (i_req_last),
        .o_req_ready (o_req_ready),
        .o_tx_data   (o_tx_data),
        .o_tx_valid  (o_tx_valid),
        .i_tx_ready  (i_tx_ready),
        .o_grant     (o_grant),
        .o_busy      (o_busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] dq[NCH][$];
    bit         lq[NCH][$];
    bit         pres[NCH];
    int         stall[NCH];
    int         m_own = -1;
    int         m_ptr = 0;
    int         m_cnt = 0;
    bit         m_hdr = 1'b0;
    int         vprob = 100;
    int         rmode = 2;
    int         cyc   = 0;
    logic [7:0] txlog[$];
    logic [7:0] explog[$];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int pending();
        int s = 0;
        for (int c = 0; c < NCH; c++) s += dq[c].size();
        return s;
    endfunction

    task automatic send(int ch, int base, int n);
        for (int i = 0; i < n; i++) begin
            dq[ch].push_back(8'(base + i));
            lq[ch].push_back(i == n - 1);
        end
    endtask

    task automatic exp_hdr(int ch);
        if (HDR) explog.push_back(8'h80 | 8'(ch));
    endtask

    task automatic exp_bytes(int base, int n);
        for (int i = 0; i < n; i++) explog.push_back(8'(base + i));
    endtask

    task automatic expect_log(string tag);
        chk({tag, "_len"}, txlog.size(), explog.size());
        for (int i = 0; i < txlog.size() && i < explog.size(); i++) chk(tag, txlog[i], explog[i]);
        txlog.delete();
        explog.delete();
    endtask

    // producers: hold a byte presented until accepted, optionally stalled
    task automatic drive();
        for (int c = 0; c < NCH; c++) begin
            if (stall[c] > 0) stall[c]--;
            else if (!pres[c] && dq[c].size() > 0 && int'($urandom_range(99)) < vprob) pres[c] = 1'b1;
            i_req_valid[c]          = pres[c];
            i_req_data[c*DW +: DW]  = pres[c] ? dq[c][0] : 8'($urandom);
            i_req_last[c]           = pres[c] ? lq[c][0] : 1'($urandom);
        end
        i_tx_ready = (rmode == 2) ? 1'b1 : (rmode == 1) ? (cyc % 10 == 0) : ($urandom_range(1) == 1);
        cyc++;
    endtask

    task automatic check();
        logic [NCH-1:0] eg, er;
        logic           ev;
        logic [7:0]     ed;
        eg = (m_own >= 0) ? NCH'(1 << m_own) : '0;
        er = '0;
        ev = 1'b0;
        ed = 8'h00;
        if (m_own >= 0 && m_hdr) begin
            ev = 1'b1;
            ed = 8'h80 | 8'(m_own);
        end else if (m_own >= 0) begin
            ev = pres[m_own];
            if (ev) ed = dq[m_own][0];
            er = i_tx_ready ? eg : '0;
        end
        chk("grant", o_grant, eg);
        chk("busy", o_busy, m_own >= 0);
        chk("tx_valid", o_tx_valid, ev);
        chk("tx_data", o_tx_data, ed);
        chk("req_ready", o_req_ready, er);
    endtask

    // reference: owner/pointer/count bookkeeping over the producer queues
    task automatic model();
        bit l;
        if (o_tx_valid && i_tx_ready) txlog.push_back(o_tx_data);
        if (m_own < 0) begin
            for (int i = 0; i < NCH; i++)
                if (m_own < 0 && pres[(m_ptr + i) % NCH]) begin
                    m_own = (m_ptr + i) % NCH;
                    m_cnt = 0;
                    m_hdr = HDR;
                end
        end else if (m_hdr) begin
            if (i_tx_ready) m_hdr = 1'b0;
        end else if (pres[m_own] && i_tx_ready) begin
            l = lq[m_own][0];
            void'(dq[m_own].pop_front());
            void'(lq[m_own].pop_front());
            pres[m_own] = 1'b0;
            m_cnt++;
            if (l || m_cnt == MAXB) begin
                m_ptr = (m_own + 1) % NCH;
                m_own = -1;
            end
        end
    endtask

    task automatic step();
        drive();
        #1;
        check();
        model();
        @(negedge i_clk);
    endtask

    task automatic run_idle(int budget);
        int n = 0;
        while ((m_own >= 0 || pending() > 0) && n < budget) begin
            step();
            n++;
        end
        chk("drain_timeout", (m_own >= 0 || pending() > 0), 0);
        step();
    endtask

    task automatic wait_pop(int ch, int sz, int budget);
        int n = 0;
        while (dq[ch].size() > sz && n < budget) begin
            step();
            n++;
        end
        chk("pop_timeout", dq[ch].size() > sz, 0);
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_grant"}, o_grant, 0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_txv"}, o_tx_valid, 0);
        chk({tag, "_txd"}, o_tx_data, 0);
        chk({tag, "_rdy"}, o_req_ready, 0);
    endtask

    initial begin
        i_rst       = 1'b1;
        i_req_valid = '1;
        i_req_data  = '1;
        i_req_last  = '0;
        i_tx_ready  = 1'b1;
        #1;
        chk_zero("rst0");
        @(negedge i_clk);
        @(negedge i_clk);
        chk_zero("rst1");
        i_req_valid = '0;
        i_rst = 1'b0;

        // single channel, ready pulsed once every 10 cycles
        rmode = 1;
        send(1, 'hA1, 3);
        exp_hdr(1);
        exp_bytes('hA1, 3);
        run_idle(400);
        expect_log("single");

        // contention from pointer 0 (a ch3 packet first brings the pointer to 0)
        rmode = 2;
        send(3, 'h3F, 1);
        run_idle(50);
        txlog.delete();
        send(0, 'h01, 2);
        send(2, 'h21, 2);
        send(3, 'h31, 2);
        exp_hdr(0); exp_bytes('h01, 2);
        exp_hdr(2); exp_bytes('h21, 2);
        exp_hdr(3); exp_bytes('h31, 2);
        run_idle(100);
        expect_log("contend");

        // burst limit: ch3 6-byte packet split around waiting ch1
        send(3, 'h41, 6);
        step();
        send(1, 'h11, 2);
        exp_hdr(3); exp_bytes('h41, 4);
        exp_hdr(1); exp_bytes('h11, 2);
        exp_hdr(3); exp_bytes('h45, 2);
        run_idle(200);
        expect_log("burst");

        // stall: ch0 drops valid for 20 cycles mid-packet while ch2 waits
        send(0, 'h51, 4);
        wait_pop(0, 3, 100);
        stall[0] = 20;
        send(2, 'h61, 1);
        repeat (10) step();
        #1;
        chk("stall_grant", o_grant, 4'b0001);
        chk("stall_txv", o_tx_valid, 0);
        exp_bytes('h52, 3);
        exp_hdr(2); exp_bytes('h61, 1);
        txlog.delete();
        txlog.push_back(8'h52);
        explog.delete();
        exp_bytes('h52, 3);
        exp_hdr(2); exp_bytes('h61, 1);
        txlog.delete();
        run_idle(200);
        explog.delete();
        exp_bytes('h52, 3);
        exp_hdr(2); exp_bytes('h61, 1);
        expect_log("stall");

        // reset mid-packet with pointer at 3, then ch2 and ch3 compete from pointer 0
        send(2, 'h70, 1);
        run_idle(50);
        send(1, 'h71, 4);
        wait_pop(1, 3, 100);
        drive();
        #1;
        i_rst = 1'b1;
        #1;
        chk_zero("rst_mid");
        for (int c = 0; c < NCH; c++) begin
            dq[c].delete();
            lq[c].delete();
            pres[c]  = 1'b0;
            stall[c] = 0;
        end
        m_own = -1; m_ptr = 0; m_cnt = 0; m_hdr = 1'b0;
        i_req_valid = '0;
        @(negedge i_clk);
        i_rst = 1'b0;
        txlog.delete();
        explog.delete();
        send(3, 'hB1, 1);
        send(2, 'h91, 1);
        exp_hdr(2); exp_bytes('h91, 1);
        exp_hdr(3); exp_bytes('hB1, 1);
        run_idle(100);
        expect_log("post_reset");

        // single-byte packet from ch2 (header 8'h82 first when enabled)
        send(2, 'h55, 1);
        exp_hdr(2); exp_bytes('h55, 1);
        run_idle(50);
        expect_log("hdr");

        // randomized traffic, stalls and back-pressure
        rmode = 0;
        vprob = 60;
        for (int k = 0; k < 3000; k++) begin
            int c;
            c = int'($urandom_range(NCH - 1));
            if ($urandom_range(7) == 0 && dq[c].size() < 8)
                send(c, int'($urandom_range(255)), int'($urandom_range(6, 1)));
            if ($urandom_range(63) == 0 && !pres[c]) stall[c] = int'($urandom_range(15, 1));
            step();
        end
        rmode = 2;
        run_idle(3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
